// File: rtl/rpe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rpe_pkg
// Brief    : Shared widths, weight-code layout and psum sizing for rpe_db.
// Revision : 1.0
// ============================================================================
package rpe_pkg;

    localparam int DEF_SIZE  = 8;
    localparam int DEF_ACT_W = 7;
    localparam int DEF_WGT_W = 4;
    localparam int DEF_SHIFT = 3;

    // Weight code: [WGT_W-1:0] signed weight, [WGT_W] mode select.
    localparam int DEF_MODE_BIT = DEF_WGT_W;

    typedef enum logic {
        MODE_ODD   = 1'b0,
        MODE_SHIFT = 1'b1
    } wmode_e;

    // Bits needed to hold SIZE accumulated worst-case products.
    function automatic int psum_width(input int size, input int act_w,
                                      input int wgt_w, input int shift);
        return act_w + 1 + wgt_w + shift + 1 + $clog2(size);
    endfunction

    // One spare bit over the minimum keeps chained sums clear of the edge.
    localparam int DEF_PSUM_W = psum_width(DEF_SIZE, DEF_ACT_W, DEF_WGT_W, DEF_SHIFT) + 1;

endpackage
`default_nettype wire

// File: rtl/rpe_db_if.sv
`default_nettype none
// ============================================================================
// Module   : rpe_db_if
// Brief    : Weight, swap, activation and psum links of one PE.
// Revision : 1.0
// ============================================================================
interface rpe_db_if #(
    parameter int ACT_W  = 7,
    parameter int WGT_W  = 4,
    parameter int PSUM_W = 20
);
    logic [WGT_W:0]    w_in;
    logic              w_in_valid;
    logic [WGT_W:0]    w_out;
    logic              w_out_valid;
    logic              swap_in;
    logic              swap_out;
    logic [ACT_W-1:0]  act_in;
    logic              act_in_valid;
    logic [ACT_W-1:0]  act_out;
    logic              act_out_valid;
    logic [PSUM_W-1:0] psum_in;
    logic [PSUM_W-1:0] psum_out;
    logic              psum_out_valid;
    logic              ovf;

    modport master (
        output w_in, w_in_valid, swap_in, act_in, act_in_valid, psum_in,
        input  w_out, w_out_valid, swap_out, act_out, act_out_valid,
               psum_out, psum_out_valid, ovf
    );

    modport slave (
        input  w_in, w_in_valid, swap_in, act_in, act_in_valid, psum_in,
        output w_out, w_out_valid, swap_out, act_out, act_out_valid,
               psum_out, psum_out_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/rpe_mac.sv
`default_nettype none
// ============================================================================
// Module   : rpe_mac
// Brief    : Combinational compressed-code MAC with wrap or saturating add.
// Revision : 1.0
// ============================================================================
module rpe_mac
    import rpe_pkg::*;
#(
    parameter int ACT_W  = DEF_ACT_W,
    parameter int WGT_W  = DEF_WGT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int SAT    = 0
) (
    input  wire logic [ACT_W-1:0]  i_act,
    input  wire logic [WGT_W:0]    i_w_code,
    input  wire logic [PSUM_W-1:0] i_psum,
    output logic      [PSUM_W-1:0] o_psum,
    output logic                   o_ovf
);
    localparam int MODE_BIT = WGT_W;
    localparam int SUM_W    = PSUM_W + 1;

    logic signed [SUM_W-1:0] a_ext;
    logic signed [SUM_W-1:0] w_ext;
    logic signed [SUM_W-1:0] w_odd_ext;
    logic signed [SUM_W-1:0] psum_ext;
    logic signed [SUM_W-1:0] prod;
    logic signed [SUM_W-1:0] sum;
    wmode_e                  mode;

    // Activation LSB is implied 1; 2w+1 is just the weight with a 1 appended.
    assign a_ext     = {{(SUM_W-ACT_W-1){i_act[ACT_W-1]}}, i_act, 1'b1};
    assign w_ext     = {{(SUM_W-WGT_W){i_w_code[WGT_W-1]}}, i_w_code[WGT_W-1:0]};
    assign w_odd_ext = {{(SUM_W-WGT_W-1){i_w_code[WGT_W-1]}}, i_w_code[WGT_W-1:0], 1'b1};
    assign psum_ext  = {i_psum[PSUM_W-1], i_psum};
    assign mode      = wmode_e'(i_w_code[MODE_BIT]);

    always_comb begin
        prod = a_ext * w_odd_ext;
        if (mode == MODE_SHIFT) begin
            prod = (a_ext * w_ext) <<< (SHIFT + 1);
        end
    end

    assign sum   = prod + psum_ext;
    assign o_ovf = sum[PSUM_W] ^ sum[PSUM_W-1];

    generate
        if (SAT != 0) begin : g_sat
            always_comb begin
                o_psum = sum[PSUM_W-1:0];
                if (o_ovf) begin
                    o_psum = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                         : {1'b0, {(PSUM_W-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign o_psum = sum[PSUM_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rpe_db.sv
`default_nettype none
// ============================================================================
// Module   : rpe_db
// Brief    : Double-buffered reduced-precision weight-stationary PE.
// Revision : 1.0
// ============================================================================
module rpe_db
    import rpe_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int ACT_W  = DEF_ACT_W,
    parameter int WGT_W  = DEF_WGT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int PSUM_W = psum_width(SIZE, ACT_W, WGT_W, SHIFT) + 1,
    parameter int SAT    = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    rpe_db_if.slave   bus
);
    logic [WGT_W:0]    shadow_q, shadow_d;
    logic [WGT_W:0]    active_q, active_d;
    logic              swap_q,   swap_d;
    logic [ACT_W-1:0]  act_q,    act_d;
    logic              act_vld_q, act_vld_d;
    logic [PSUM_W-1:0] psum_q,   psum_d;
    logic              psum_vld_q, psum_vld_d;
    logic              ovf_q,    ovf_d;

    logic [PSUM_W-1:0] mac_psum;
    logic              mac_ovf;

    // MAC always sees the pre-edge active weight, so a swap lands next cycle.
    rpe_mac #(
        .ACT_W  (ACT_W),
        .WGT_W  (WGT_W),
        .SHIFT  (SHIFT),
        .PSUM_W (PSUM_W),
        .SAT    (SAT)
    ) u_mac (
        .i_act    (bus.act_in),
        .i_w_code (active_q),
        .i_psum   (bus.psum_in),
        .o_psum   (mac_psum),
        .o_ovf    (mac_ovf)
    );

    always_comb begin
        shadow_d   = bus.w_in_valid ? bus.w_in : shadow_q;
        active_d   = bus.swap_in ? shadow_q : active_q;
        swap_d     = bus.swap_in;
        act_d      = bus.act_in_valid ? bus.act_in : act_q;
        act_vld_d  = bus.act_in_valid;
        psum_d     = bus.act_in_valid ? mac_psum : psum_q;
        psum_vld_d = bus.act_in_valid;
        ovf_d      = ovf_q | (bus.act_in_valid & mac_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            active_q   <= '0;
            swap_q     <= 1'b0;
            act_q      <= '0;
            act_vld_q  <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            swap_q     <= swap_d;
            act_q      <= act_d;
            act_vld_q  <= act_vld_d;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.w_out          = shadow_q;
    assign bus.w_out_valid    = bus.w_in_valid;
    assign bus.swap_out       = swap_q;
    assign bus.act_out        = act_q;
    assign bus.act_out_valid  = act_vld_q;
    assign bus.psum_out       = psum_q;
    assign bus.psum_out_valid = psum_vld_q;
    assign bus.ovf            = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rpe_db.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpe_db
// Brief    : Directed checks of rpe_db in wrap (u0) and saturate (u1) builds.
// Revision : 1.0
// ============================================================================
module tb_rpe_db;
    localparam int ACT_W  = 7;
    localparam int WGT_W  = 4;
    localparam int PSUM_W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    rpe_db_if #(.ACT_W(ACT_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W)) bus0 ();
    rpe_db_if #(.ACT_W(ACT_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W)) bus1 ();

    rpe_db #(.SIZE(8), .ACT_W(ACT_W), .WGT_W(WGT_W), .SHIFT(3), .PSUM_W(PSUM_W), .SAT(0))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    rpe_db #(.SIZE(8), .ACT_W(ACT_W), .WGT_W(WGT_W), .SHIFT(3), .PSUM_W(PSUM_W), .SAT(1))
        u1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [6:0]  act;
        logic [4:0]  wcode;
        int          psum;
        int          exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] w, input logic wv, input logic sw,
                         input logic [6:0] a, input logic av, input int ps);
        bus0.w_in = w;  bus0.w_in_valid = wv; bus0.swap_in = sw;
        bus0.act_in = a; bus0.act_in_valid = av; bus0.psum_in = ps[PSUM_W-1:0];
        bus1.w_in = w;  bus1.w_in_valid = wv; bus1.swap_in = sw;
        bus1.act_in = a; bus1.act_in_valid = av; bus1.psum_in = ps[PSUM_W-1:0];
    endtask

    function automatic int ps0();
        return int'($signed(bus0.psum_out));
    endfunction

    function automatic int ps1();
        return int'($signed(bus1.psum_out));
    endfunction

    task automatic load_swap(input logic [4:0] w);
        drive(w, 1'b1, 1'b0, 7'd0, 1'b0, 0);
        tick();
        drive(5'd0, 1'b0, 1'b1, 7'd0, 1'b0, 0);
        tick();
        drive(5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psum"},    ps0(), 0);
        chk({tag, "_pvalid"},  int'(bus0.psum_out_valid), 0);
        chk({tag, "_avalid"},  int'(bus0.act_out_valid), 0);
        chk({tag, "_act"},     int'(bus0.act_out), 0);
        chk({tag, "_wout"},    int'(bus0.w_out), 0);
        chk({tag, "_swapout"}, int'(bus0.swap_out), 0);
        chk({tag, "_ovf0"},    int'(bus0.ovf), 0);
        chk({tag, "_ovf1"},    int'(bus1.ovf), 0);
    endtask

    initial begin
        // A = {act,1}; m0: A*(2w+1); m1: (A*w)<<4
        vecs[0] = '{act: 7'd2,    wcode: 5'h03, psum: 100, exp: 135};
        vecs[1] = '{act: 7'd2,    wcode: 5'h13, psum: 100, exp: 340};
        vecs[2] = '{act: 7'h7F,   wcode: 5'h0E, psum: 0,   exp: 3};
        vecs[3] = '{act: 7'h40,   wcode: 5'h07, psum: 0,   exp: -1905};
        vecs[4] = '{act: 7'h7F,   wcode: 5'h18, psum: -50, exp: 78};

        drive(5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].wcode, 1'b1, 1'b0, 7'd0, 1'b0, 0);
            tick();
            chk($sformatf("v%0d_wout", i), int'(bus0.w_out), int'(vecs[i].wcode));
            drive(5'd0, 1'b0, 1'b1, 7'd0, 1'b0, 0);
            tick();
            chk($sformatf("v%0d_swapout", i), int'(bus0.swap_out), 1);
            drive(5'd0, 1'b0, 1'b0, vecs[i].act, 1'b1, vecs[i].psum);
            tick();
            chk($sformatf("v%0d_psum0", i), ps0(), vecs[i].exp);
            chk($sformatf("v%0d_psum1", i), ps1(), vecs[i].exp);
            chk($sformatf("v%0d_pvalid", i), int'(bus0.psum_out_valid), 1);
            chk($sformatf("v%0d_act", i), int'(bus0.act_out), int'(vecs[i].act));
            drive(5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 0);
            tick();
            chk($sformatf("v%0d_pvalid_drop", i), int'(bus0.psum_out_valid), 0);
            chk($sformatf("v%0d_hold", i), ps0(), vecs[i].exp);
        end
        chk("no_ovf_yet", int'(bus0.ovf), 0);

        // Double buffering: shadow load and swap never disturb in-flight compute
        load_swap(5'h03);
        drive(5'd0, 1'b0, 1'b0, 7'd2, 1'b1, 0);
        tick();
        chk("db_c1", ps0(), 35);
        drive(5'h01, 1'b1, 1'b0, 7'd2, 1'b1, 0);
        tick();
        chk("db_c2", ps0(), 35);
        chk("db_shadow", int'(bus0.w_out), 1);
        chk("db_wvalid", int'(bus0.w_out_valid), 1);
        drive(5'h00, 1'b0, 1'b1, 7'd2, 1'b1, 0);
        tick();
        chk("db_swapcycle", ps0(), 35);
        chk("db_swapout_hi", int'(bus0.swap_out), 1);
        drive(5'h00, 1'b0, 1'b0, 7'd2, 1'b1, 0);
        tick();
        chk("db_newweight", ps0(), 15);
        chk("db_swapout_lo", int'(bus0.swap_out), 0);
        chk("db_wvalid_lo", int'(bus0.w_out_valid), 0);

        // Overflow: wrap versus clamp, then sticky
        load_swap(5'h03);
        drive(5'd0, 1'b0, 1'b0, 7'd2, 1'b1, 524280);
        tick();
        chk("ovf_wrap", ps0(), -524261);
        chk("ovf_sat", ps1(), 524287);
        chk("ovf_flag0", int'(bus0.ovf), 1);
        chk("ovf_flag1", int'(bus1.ovf), 1);
        drive(5'd0, 1'b0, 1'b0, 7'd2, 1'b1, 0);
        tick();
        chk("ovf_sticky0", int'(bus0.ovf), 1);
        chk("ovf_sticky1", int'(bus1.ovf), 1);
        chk("post_ovf_mac", ps1(), 35);
        load_swap(5'h0E);
        drive(5'd0, 1'b0, 1'b0, 7'd2, 1'b1, -524288);
        tick();
        chk("neg_wrap", ps0(), 524273);
        chk("neg_sat", ps1(), -524288);

        // Reset in the middle of a weight burst with compute active
        drive(5'h05, 1'b1, 1'b0, 7'd2, 1'b1, 100);
        tick();
        rst = 1'b1;
        drive(5'h05, 1'b1, 1'b1, 7'd2, 1'b1, 100);
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        drive(5'd0, 1'b0, 1'b0, 7'd2, 1'b1, 100);
        tick();
        chk("rst_w0_mac", ps0(), 105);
        chk("rst_w0_valid", int'(bus0.psum_out_valid), 1);
        drive(5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rpe_db.md
Name: rpe_db

Overview:
- Parametrised, double-buffered reduced-precision processing element (PE) for the weight-stationary systolic array.
- Computes partial-sum MAC using the compressed activation/weight encoding: odd-activation implied LSB, signed weight code with mode bit.
- New relative to the previous PE: weights shift into a shadow register while compute continues, and a swap token promotes them. Also adds valid-qualified activation/psum pipelines, sync reset and optional saturating accumulation.

Parameters:
- SIZE, 8, array dimension; sets PSUM_W headroom.
- ACT_W, 7, stored activation bits; effective activation A = {act,1'b1}, signed, ACT_W+1 bits.
- WGT_W, 4, signed two's-complement weight field; weight code is WGT_W+1 bits, MSB = mode.
- SHIFT, 3, extra left shift applied in mode 1.
- PSUM_W, ACT_W+1+WGT_W+SHIFT+1+$clog2(SIZE) (=19 → use 20 by default), partial-sum width.
- SAT, 0, 1 = saturating psum add; 0 = wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- w_in  in  WGT_W+1  weight code from PE above.
- w_in_valid  in  1  shift enable for the weight chain.
- w_out  out  WGT_W+1  shadow register contents, to PE below.
- w_out_valid  out  1  combinational copy of w_in_valid.
- swap_in  in  1  single-cycle token: promote shadow to active.
- swap_out  out  1  swap_in registered, to PE to the right.
- act_in  in  ACT_W  stored activation.
- act_in_valid  in  1  activation qualifier.
- act_out  out  ACT_W  registered act_in.
- act_out_valid  out  1  registered act_in_valid.
- psum_in  in  PSUM_W  partial sum from above.
- psum_out  out  PSUM_W  registered MAC result.
- psum_out_valid  out  1  registered act_in_valid.
- ovf  out  1  sticky overflow flag; cleared only by rst.

Behaviour:
- Reset (sync, rst=1 at posedge): shadow, active weight, act_out, psum_out, all valids, swap_out and ovf are set to 0. Reset overrides every other input in that cycle.
- Weight chain: if w_in_valid, shadow <= w_in. w_out is always the shadow value. Loading never stalls compute.
- Swap: if swap_in, active <= shadow (the pre-edge shadow value). swap_out <= swap_in.
- Swap + w_in_valid in the same cycle: active takes the old shadow, and shadow takes w_in.
- Compute path, on act_in_valid=1 at the edge:
  - psum_out <= MAC(active pre-edge, act_in, psum_in).
  - act_out <= act_in.
  - act_out_valid <= 1 and psum_out_valid <= 1.
  - Latency is 1 cycle.
  - A swap in the same cycle does not affect this result; the new weight applies from the next cycle.
- act_in_valid=0: act_out and psum_out hold; act_out_valid <= 0; psum_out_valid <= 0.
- MAC arithmetic:
  - A = signed {act,1'b1}; w = signed weight field; m = weight-code MSB.
  - m=0: prod = 2*A*w + A, i.e. A*(2w+1).
  - m=1: prod = (A*w) << (SHIFT+1).
  - prod is sign-extended to PSUM_W+1, and sum = prod + psum_in.
  - SAT=0: psum_out = sum[PSUM_W-1:0] (wrap). ovf <= 1 if the signed overflow condition is met.
  - SAT=1: clamp to +2^(PSUM_W-1)-1 or -2^(PSUM_W-1) on overflow, and ovf <= 1.
  - ovf is only evaluated when act_in_valid=1.
- Reset mid-load or mid-swap: the partial chain contents are discarded. Software reloads all SIZE weights and then reissues swap.

Decomposition:
- Package rpe_pkg: default widths, a PSUM_W derivation function, and weight-code field positions (MODE_BIT=WGT_W).
- Combinational sub-module rpe_mac (A decode, product, mode select, add/saturate, ovf detect).
- rpe_db holds all registers.

Test Plan:
- Baseline MAC: act_in=2 (A=5), w=3 m=0, swap, psum_in=100 → psum_out=135 one cycle after act_in_valid; psum_out_valid=1 for exactly that cycle.
- Mode 1: same A=5, w=3 m=1, SHIFT=3, psum_in=100 → psum_out=340.
- Negative values: act_in=7'h7F (A=-1), w=4'hE (-2) m=0, psum_in=0 → psum_out=3.
- Double buffering: active w=3 while streaming A=5 with psum_in=0 each cycle, then load w=1 into shadow mid-stream.
  - Results stay 35 until the swap cycle.
  - Compute in the swap cycle still gives 35; the next cycle gives 15.
  - swap_out pulses one cycle after swap_in.
- Overflow: PSUM_W=20, psum_in=524280, prod=35.
  - SAT=0 → psum_out=-524261 and ovf=1.
  - SAT=1 → psum_out=524287 and ovf=1.
  - ovf stays 1 until rst.
- Reset mid-operation: assert rst during a w_in_valid burst with act_in_valid=1 → next cycle all outputs=0; a post-reset MAC with no swap uses w=0 → psum_out=psum_in+A.
